// File: rtl/sad_best_mv_tracker.sv
// Tracks per-sub-block minimum SAD and its search-window coordinates over one
// CTU search, then offers the four winners downstream via valid/ready.
module sad_best_mv_tracker #(
  parameter int SAD_W = 16,
  parameter int ROW_W = 7,
  parameter int COL_W = 5,
  parameter int CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sad_valid,
  input  logic [SAD_W-1:0]     sad_in,
  input  logic [1:0]           cb_id,
  input  logic [ROW_W-1:0]     search_row,
  input  logic [COL_W-1:0]     search_col,
  input  logic                 search_done,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*SAD_W-1:0]   best_sad,
  output logic [4*ROW_W-1:0]   best_row,
  output logic [4*COL_W-1:0]   best_col,
  output logic [4*CNT_W-1:0]   cand_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [SAD_W-1:0] SAD_INIT = {SAD_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t state;

  // Packed lane arrays flatten so that lane n lands at [n*W +: W].
  logic [3:0][SAD_W-1:0] sad_q;
  logic [3:0][ROW_W-1:0] row_q;
  logic [3:0][COL_W-1:0] col_q;
  logic [3:0][CNT_W-1:0] cnt_q;

  assign best_sad = sad_q;
  assign best_row = row_q;
  assign best_col = col_q;
  assign cand_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        sad_q[k] <= SAD_INIT;
        row_q[k] <= '0;
        col_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= TRACK;
            busy  <= 1'b1;
            for (int k = 0; k < 4; k++) begin
              sad_q[k] <= SAD_INIT;
              row_q[k] <= '0;
              col_q[k] <= '0;
              cnt_q[k] <= '0;
            end
          end
        end

        TRACK: begin
          // Strict less-than keeps the earliest candidate on ties, and an
          // all-ones SAD can never displace the initial value.
          if (sad_valid) begin
            if (sad_in < sad_q[cb_id]) begin
              sad_q[cb_id] <= sad_in;
              row_q[cb_id] <= search_row;
              col_q[cb_id] <= search_col;
            end
            if (cnt_q[cb_id] != CNT_MAX) begin
              cnt_q[cb_id] <= cnt_q[cb_id] + 1'b1;
            end
          end
          if (search_done) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end

        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
